// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types, widths and helpers for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int WORD_W         = 64;
  localparam int ADDR_W         = 64;
  localparam int BYTES_PER_WORD = 8;

  // Sequencer states: arbitrate, one memory cycle, hold the response.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Everything the sequencer needs to remember about an accepted request.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // A word access is legal when its last byte lies inside the memory and,
  // if alignment is enforced, it starts on a word boundary. The end address
  // is formed one bit wider so that a wrap past 2^64 reads as out of range.
  function automatic logic addr_legal(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W:0]   last_byte,
    input logic              align_check
  );
    logic [ADDR_W:0] end_byte;
    logic            misaligned;
    end_byte   = {1'b0, addr} + (ADDR_W+1)'(BYTES_PER_WORD - 1);
    misaligned = align_check && (addr[2:0] != 3'd0);
    return (end_byte <= last_byte) && !misaligned;
  endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant. A lone requester always wins; on
//                a tie the port that did not win last time is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from the request pair and the previous winner.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter and sequencer in front of the shared
//                64-bit big-endian data memory. One request is in flight at a
//                time: IDLE (grant) -> ACCESS (one memory cycle) -> RESP.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_SIZE    = 8192,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  // Port 0 : CPU load/store unit
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [WORD_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [WORD_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  // Port 1 : DMA / debug loader
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [WORD_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [WORD_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  // Memory side
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [WORD_W-1:0] mem_data
);

  // Highest legal byte address, one bit wider than the address bus.
  localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_SIZE - 1);

  state_e            state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q,       port_d;
  mem_req_t          req_q,        req_d;
  logic [WORD_W-1:0] rdata_q,      rdata_d;
  logic              err_q,        err_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;

  logic [1:0] grant;
  logic       sel_port;
  mem_req_t   sel_req;
  logic       sel_legal;
  logic       req_hs;
  logic       rsp_ready_sel;
  logic       drive_bus;

  rr_arb2 u_arb (
    .req        ({p1_req_valid, p0_req_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Pick the winning port's request and decide whether it is legal.
  always_comb begin
    sel_port      = grant[1];
    sel_req.we    = sel_port ? p1_req_we    : p0_req_we;
    sel_req.addr  = sel_port ? p1_req_addr  : p0_req_addr;
    sel_req.wdata = sel_port ? p1_req_wdata : p0_req_wdata;
    sel_legal     = addr_legal(sel_req.addr, LAST_BYTE, ALIGN_CHECK);
    // Ready is held low while reset is asserted so nothing handshakes then.
    p0_req_ready  = (state_q == IDLE) && grant[0] && !rst;
    p1_req_ready  = (state_q == IDLE) && grant[1] && !rst;
    req_hs        = p0_req_ready || p1_req_ready;
    rsp_ready_sel = port_q ? p1_rsp_ready : p0_rsp_ready;
  end

  // Next-state and datapath updates for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          port_d       = sel_port;
          last_grant_d = sel_port;
          req_d        = sel_req;
          rdata_d      = '0;
          err_d        = 1'b0;
          if (sel_legal) begin
            // mem_addr only moves for real accesses, so it never shows an
            // address that is not about to be used.
            mem_addr_d = sel_req.addr;
            state_d    = ACCESS;
          end else begin
            // Illegal addresses skip the memory entirely.
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        // Read data is captured at the edge that closes the access cycle.
        if (!req_q.we) begin
          rdata_d = mem_data;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_sel) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset lands immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      req_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      req_q        <= req_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Response and memory-side outputs decoded from the registered state.
  always_comb begin
    p0_rsp_valid = (state_q == RESP) && !port_q;
    p1_rsp_valid = (state_q == RESP) &&  port_q;
    p0_rsp_rdata = p0_rsp_valid ? rdata_q : '0;
    p1_rsp_rdata = p1_rsp_valid ? rdata_q : '0;
    p0_rsp_err   = p0_rsp_valid && err_q;
    p1_rsp_err   = p1_rsp_valid && err_q;
    // Derived from state so that an asynchronous reset drops it at once.
    drive_bus    = (state_q == ACCESS) && req_q.we;
    mem_rw       = drive_bus;
    mem_addr     = mem_addr_q;
  end

  // The shared data bus is only driven during a write access cycle.
  assign mem_data = drive_bus ? req_q.wdata : {WORD_W{1'bz}};

endmodule : dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared 64-bit byte-addressed data memory.
- Requester 0 is the CPU load/store unit; requester 1 is the DMA/debug loader.
- Accepts one request at a time with valid/ready, drives mem_rw/mem_addr and the bidirectional mem_data bus, and returns read data or an error per port.
- Word layout: big-endian, so byte [addr] = bits 63:56 and byte [addr+7] = bits 7:0.

Parameters:
- MEM_SIZE, 8192, memory depth in bytes; a legal access satisfies addr+7 <= MEM_SIZE-1.
- ALIGN_CHECK, 1, when 1, addr[2:0] != 0 is an error; when 0, unaligned access is allowed.

Ports:
- clk  input  1  system clock; memory commits writes on negedge clk.
- rst  input  1  reset, asynchronous, active-high.
- p0_req_valid / p1_req_valid  input  1  request valid per port.
- p0_req_ready / p1_req_ready  output  1  request accepted this cycle.
- p0_req_we / p1_req_we  input  1  1 = store, 0 = load.
- p0_req_addr / p1_req_addr  input  64  byte address.
- p0_req_wdata / p1_req_wdata  input  64  store data.
- p0_rsp_valid / p1_rsp_valid  output  1  response valid, held until rsp_ready.
- p0_rsp_ready / p1_rsp_ready  input  1  response consumed.
- p0_rsp_rdata / p1_rsp_rdata  output  64  load data; 0 for stores and errors.
- p0_rsp_err / p1_rsp_err  output  1  bounds or alignment error.
- mem_rw  output  1  1 = write, 0 = read.
- mem_addr  output  64  memory byte address.
- mem_data  inout  64  driven only during a write ACCESS cycle, otherwise high-Z.

Behaviour:
- States: IDLE, ACCESS, RESP.

Reset:
- Asynchronous; takes effect immediately.
- State goes to IDLE; all ready, rsp_valid and err outputs go to 0.
- rdata registers, mem_addr and mem_rw go to 0; mem_data goes to high-Z; last_grant goes to 1.

IDLE:
- px_req_ready is combinationally 1 only for the granted valid port.
- Arbitration is round-robin: on a tie, the port not equal to last_grant wins. The first tie after reset therefore goes to port 0.
- On a handshake at posedge N, the arbiter latches port, we, addr and wdata, and updates last_grant.
- If the address is illegal (bounds or alignment), it goes straight to RESP with err=1 and rdata=0. No memory cycle is issued and mem_rw stays 0.
- Otherwise it goes to ACCESS.

ACCESS (cycle N+1, exactly one cycle):
- mem_addr = latched addr; mem_rw = latched we.
- For a write, mem_data = wdata; memory commits at the negedge inside this cycle.
- For a read, mem_data is sampled at posedge N+2 into the rdata register.
- Always goes to RESP.

RESP:
- Granted port's rsp_valid = 1 with rdata/err stable until its rsp_ready is 1; rsp_ready is sampled at posedge.
- On that handshake the state returns to IDLE and rsp_valid drops.
- New requests are not accepted in RESP; minimum throughput is one access per 3 cycles.

Outside ACCESS:
- mem_rw = 0 and mem_data is high-Z.
- mem_addr holds its last value (glitch-free reads only).

Other rules:
- Only one port's ready or rsp_valid is ever 1.
- Request signals may change freely when ready = 0.
- The latched address is not recomputed; a bounds check that overflows 64 bits counts as illegal.
- Reset during ACCESS on a write: mem_rw drops asynchronously. Whether the negedge write lands is undefined, and the memory is reset by the same rst.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, ACCESS, RESP};
  - WORD_W = 64, ADDR_W = 64, BYTES_PER_WORD = 8;
  - request struct {we, addr, wdata}.
- Sub-module rr_arb2: 2-way round-robin grant (req[1:0], last_grant in; grant[1:0] out), purely combinational.
- last_grant storage lives in dmem_arbiter.

Test Plan:
- Reset, p0 store 0x0C3C3EAAF00FCC33 at addr 0x10, then p0 load 0x10 -> p0_rsp_rdata = 0x0C3C3EAAF00FCC33, err = 0. Store response arrives cycle N+2 with rdata = 0.
- p0 and p1 both issue loads continuously -> grants alternate p0, p1, p0, p1. Each response is 2 cycles after acceptance, and mem_data is high-Z throughout.
- p1 store at addr 8184 -> legal, err = 0. p1 store at addr 8185 -> err = 1, mem_rw never asserted, and a later load at 8184 returns the original data.
- ALIGN_CHECK = 1, load at addr 0x11 -> err = 1. ALIGN_CHECK = 0, same load -> err = 0, with byte ordering checked against a reference model.
- Hold p0_rsp_ready = 0 for 5 cycles while p1 is requesting -> p0 rsp_valid/rdata stay stable and p1_req_ready stays 0 until the p0 handshake.
- Assert rst mid-ACCESS on a write -> rsp_valid, ready and mem_rw go to 0 immediately, mem_data goes high-Z, and the next grant after reset goes to port 0.
